// File: rtl/fcims_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fcims_pkg : widths, item/state types shared by the FCIMS order controller  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package fcims_pkg;
    localparam int N_ITEMS = 4;
    localparam int IDX_W   = $clog2(N_ITEMS);
    localparam int CNT_W   = 4;
    localparam int PRICE_W = 4;
    localparam int TOT_W   = CNT_W + PRICE_W;
    localparam int LOW_TH  = 2;

    typedef logic [IDX_W-1:0]   item_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [PRICE_W-1:0] price_t;
    typedef logic [TOT_W-1:0]   tot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/fcims_order_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fcims_order_ctrl_if : config, order request and response handshake bundle  |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
interface fcims_order_ctrl_if;
    import fcims_pkg::*;

    logic   cfg_we;
    item_t  cfg_item;
    price_t cfg_price;
    cnt_t   cfg_count;

    logic   req_valid;
    logic   req_ready;
    item_t  req_item;
    cnt_t   req_qty;
    logic   req_sell;

    logic   rsp_valid;
    logic   rsp_ready;
    logic   rsp_ok;
    tot_t   rsp_fprice;
    cnt_t   rsp_new_ct;

    modport master (
        output cfg_we, cfg_item, cfg_price, cfg_count,
        output req_valid, req_item, req_qty, req_sell, rsp_ready,
        input  req_ready, rsp_valid, rsp_ok, rsp_fprice, rsp_new_ct
    );

    modport slave (
        input  cfg_we, cfg_item, cfg_price, cfg_count,
        input  req_valid, req_item, req_qty, req_sell, rsp_ready,
        output req_ready, rsp_valid, rsp_ok, rsp_fprice, rsp_new_ct
    );
endinterface
`default_nettype wire

// File: rtl/fcims_item_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fcims_item_table : per-item stock/price registers, 1 write, 1 async read   |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module fcims_item_table
    import fcims_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   wr_stock_en,
    input  logic   wr_price_en,
    input  item_t  wr_item,
    input  cnt_t   wr_stock,
    input  price_t wr_price,
    input  item_t  rd_item,
    output cnt_t   rd_stock,
    output price_t rd_price
);
    cnt_t   stock [N_ITEMS];
    price_t price [N_ITEMS];

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_entry
        cnt_t   stock_q;
        price_t price_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                stock_q <= '0;
                price_q <= '0;
            end else if (wr_item == item_t'(i)) begin
                if (wr_stock_en) stock_q <= wr_stock;
                if (wr_price_en) price_q <= wr_price;
            end
        end

        assign stock[i] = stock_q;
        assign price[i] = price_q;
    end

    assign rd_stock = stock[rd_item];
    assign rd_price = price[rd_item];
endmodule
`default_nettype wire

// File: rtl/fcims_order_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fcims_order_ctrl : order FSM driving the external FCIMS core, till total   |
// | Option macro     : FCIMS_LOWSTOCK_ALERT_EN (adds registered low_stock)     |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module fcims_order_ctrl
    import fcims_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    fcims_order_ctrl_if.slave  bus,
    output tot_t               total,
    output logic               core_reset,
    output logic               core_ctrl,
    output price_t             core_uprice,
    output cnt_t               core_ncel,
    output cnt_t               core_ct,
    output tot_t               core_tprice_init,
    input  tot_t               core_fprice,
    input  cnt_t               core_new_ct,
    input  tot_t               core_tprice_fin
`ifdef FCIMS_LOWSTOCK_ALERT_EN
    ,
    output logic               low_stock
`endif
);
    state_t state;
    state_t state_nxt;
    item_t  item_lat;
    cnt_t   qty_lat;
    logic   sell_lat;
    cnt_t   rd_stock;
    price_t rd_price;
    logic   accept;
    logic   cfg_wr;
    logic   reject;
    logic   commit;

    assign accept = bus.req_valid && bus.req_ready;
    assign cfg_wr = (state == IDLE) && bus.cfg_we;
    assign reject = sell_lat && (qty_lat > rd_stock);
    assign commit = (state == SAMPLE) && !reject;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.cfg_we && bus.req_valid) state_nxt = DRIVE;
            DRIVE:   state_nxt = SAMPLE;
            SAMPLE:  state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && !bus.cfg_we;
        bus.rsp_valid = (state == RESP);
        core_reset    = (state == IDLE) || (state == RESP);
    end

    // Config and commit share the single table write port; they never coincide.
    fcims_item_table u_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_stock_en (cfg_wr || commit),
        .wr_price_en (cfg_wr),
        .wr_item     (cfg_wr ? bus.cfg_item : item_lat),
        .wr_stock    (cfg_wr ? bus.cfg_count : core_new_ct),
        .wr_price    (bus.cfg_price),
        .rd_item     (item_lat),
        .rd_stock    (rd_stock),
        .rd_price    (rd_price)
    );

    assign core_ctrl        = sell_lat;
    assign core_uprice      = rd_price;
    assign core_ncel        = qty_lat;
    assign core_ct          = rd_stock;
    assign core_tprice_init = total;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            item_lat       <= '0;
            qty_lat        <= '0;
            sell_lat       <= 1'b0;
            total          <= '0;
            bus.rsp_ok     <= 1'b0;
            bus.rsp_fprice <= '0;
            bus.rsp_new_ct <= '0;
        end else begin
            if (accept) begin
                item_lat <= bus.req_item;
                qty_lat  <= bus.req_qty;
                sell_lat <= bus.req_sell;
            end
            if (state == SAMPLE) begin
                bus.rsp_ok     <= !reject;
                bus.rsp_fprice <= reject ? '0 : core_fprice;
                bus.rsp_new_ct <= reject ? rd_stock : core_new_ct;
                if (!reject) total <= core_tprice_fin;
            end
        end
    end

`ifdef FCIMS_LOWSTOCK_ALERT_EN
    item_t low_item;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            low_stock <= 1'b0;
            low_item  <= '0;
        end else if (commit) begin
            low_stock <= (core_new_ct < cnt_t'(LOW_TH));
            low_item  <= item_lat;
        end else if (cfg_wr && (bus.cfg_item == low_item) && (bus.cfg_count >= cnt_t'(LOW_TH))) begin
            low_stock <= 1'b0;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_fcims_order_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fcims_order_ctrl : order controller with a behavioural core and model   |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_fcims_order_ctrl;
    import fcims_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    tot_t   total;
    logic   core_reset;
    logic   core_ctrl;
    price_t core_uprice;
    cnt_t   core_ncel;
    cnt_t   core_ct;
    tot_t   core_tprice_init;
    tot_t   core_fprice;
    cnt_t   core_new_ct;
    tot_t   core_tprice_fin;
`ifdef FCIMS_LOWSTOCK_ALERT_EN
    logic   low_stock;
`endif

    always #5 clk = ~clk;

    fcims_order_ctrl_if bus ();

    fcims_order_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus.slave),
        .total            (total),
        .core_reset       (core_reset),
        .core_ctrl        (core_ctrl),
        .core_uprice      (core_uprice),
        .core_ncel        (core_ncel),
        .core_ct          (core_ct),
        .core_tprice_init (core_tprice_init),
        .core_fprice      (core_fprice),
        .core_new_ct      (core_new_ct),
        .core_tprice_fin  (core_tprice_fin)
`ifdef FCIMS_LOWSTOCK_ALERT_EN
        ,
        .low_stock        (low_stock)
`endif
    );

    // Reference FCIMS core: purely combinational, quiet while held in reset.
    assign core_fprice     = core_reset ? '0 : tot_t'(core_ncel) * tot_t'(core_uprice);
    assign core_new_ct     = core_reset ? '0 : (core_ctrl ? core_ct - core_ncel : core_ct + core_ncel);
    assign core_tprice_fin = core_reset ? '0 : (core_ctrl ? core_tprice_init + core_fprice
                                                          : core_tprice_init - core_fprice);

    typedef struct {
        int item; int qty; int sell; int hold;
        int ok;   int fprice; int newct; int tot;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int m_stock [N_ITEMS];
    int m_price [N_ITEMS];
    int m_total;
    int m_low;
    int m_low_item;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_ITEMS; i++) begin
            m_stock[i] = 0;
            m_price[i] = 0;
        end
        m_total    = 0;
        m_low      = 0;
        m_low_item = 0;
    endtask

    task automatic model_cfg(input int item, input int price, input int count);
        m_price[item] = price;
        m_stock[item] = count;
        if (item == m_low_item && count >= LOW_TH) m_low = 0;
    endtask

    task automatic do_cfg(input int item, input int price, input int count);
        bus.cfg_we    = 1'b1;
        bus.cfg_item  = item_t'(item);
        bus.cfg_price = price_t'(price);
        bus.cfg_count = cnt_t'(count);
        tick();
        bus.cfg_we = 1'b0;
        model_cfg(item, price, count);
    endtask

    task automatic do_order(input int item, input int qty, input int sell, input int hold,
                            output int ok, output int fprice, output int newct, output int waited);
        int exp_ok, exp_fp, exp_ct, lat;
        exp_ok = (sell != 0 && qty > m_stock[item]) ? 0 : 1;
        exp_fp = exp_ok ? ((qty * m_price[item]) & 255) : 0;
        if (exp_ok) begin
            exp_ct  = (sell != 0 ? m_stock[item] - qty : m_stock[item] + qty) & 15;
            m_total = (sell != 0 ? m_total + exp_fp : m_total - exp_fp) & 255;
            m_stock[item] = exp_ct;
            m_low      = (exp_ct < LOW_TH) ? 1 : 0;
            m_low_item = item;
        end else begin
            exp_ct = m_stock[item];
        end

        bus.req_valid = 1'b1;
        bus.req_item  = item_t'(item);
        bus.req_qty   = cnt_t'(qty);
        bus.req_sell  = sell[0];
        #1;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            tick();
            waited++;
        end
        ok = 0; fprice = 0; newct = 0;
        if (!bus.req_ready) begin
            check("req_ready_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("rsp_latency", lat, 3);
        ok     = int'(bus.rsp_ok);
        fprice = int'(bus.rsp_fprice);
        newct  = int'(bus.rsp_new_ct);
        check("rsp_ok", bus.rsp_ok, exp_ok);
        check("rsp_fprice", bus.rsp_fprice, exp_fp);
        check("rsp_new_ct", bus.rsp_new_ct, exp_ct);
        check("total", total, m_total);
`ifdef FCIMS_LOWSTOCK_ALERT_EN
        check("low_stock", low_stock, m_low);
`endif
        bus.rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_fprice", bus.rsp_fprice, exp_fp);
            check("hold_new_ct", bus.rsp_new_ct, exp_ct);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", bus.rsp_valid, 0);
    endtask

    vec_t vecs [3];
    int ok, fp, ct, wt;

    initial begin
        // Directed sequence on item0 (price 3, count 9) with hand-derived results.
        vecs[0] = '{item: 0, qty: 4, sell: 1, hold: 0, ok: 1, fprice: 12, newct: 5, tot: 12};
        vecs[1] = '{item: 0, qty: 6, sell: 1, hold: 0, ok: 0, fprice: 0,  newct: 5, tot: 12};
        vecs[2] = '{item: 0, qty: 2, sell: 0, hold: 5, ok: 1, fprice: 6,  newct: 7, tot: 6};

        reset_n       = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_item  = '0;
        bus.cfg_price = '0;
        bus.cfg_count = '0;
        bus.req_valid = 1'b0;
        bus.req_item  = '0;
        bus.req_qty   = '0;
        bus.req_sell  = 1'b0;
        bus.rsp_ready = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_total", total, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_rsp_fprice", bus.rsp_fprice, 0);
`ifdef FCIMS_LOWSTOCK_ALERT_EN
        check("rst_low_stock", low_stock, 0);
`endif
        reset_n = 1'b1;
        tick();

        do_cfg(0, 3, 9);
        for (int v = 0; v < 3; v++) begin
            do_order(vecs[v].item, vecs[v].qty, vecs[v].sell, vecs[v].hold, ok, fp, ct, wt);
            check("vec_ok", ok, vecs[v].ok);
            check("vec_fprice", fp, vecs[v].fprice);
            check("vec_new_ct", ct, vecs[v].newct);
            check("vec_total", total, vecs[v].tot);
        end

        // Config and order collide in IDLE: config wins, order goes next cycle.
        bus.cfg_we    = 1'b1;
        bus.cfg_item  = item_t'(1);
        bus.cfg_price = price_t'(5);
        bus.cfg_count = cnt_t'(8);
        bus.req_valid = 1'b1;
        bus.req_item  = item_t'(1);
        bus.req_qty   = cnt_t'(1);
        bus.req_sell  = 1'b1;
        #1;
        check("collide_req_ready", bus.req_ready, 0);
        tick();
        bus.cfg_we = 1'b0;
        model_cfg(1, 5, 8);
        #1;
        check("collide_next_ready", bus.req_ready, 1);
        do_order(1, 1, 1, 0, ok, fp, ct, wt);
        check("collide_wait", wt, 0);
        check("collide_fprice", fp, 5);
        check("collide_new_ct", ct, 7);

        // Reset asserted while the order sits in SAMPLE.
        bus.req_valid = 1'b1;
        bus.req_item  = item_t'(0);
        bus.req_qty   = cnt_t'(1);
        bus.req_sell  = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("abort_core_reset", core_reset, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_total", total, 0);
        tick();
        check("abort_rsp_quiet", bus.rsp_valid, 0);
        check("abort_req_ready", bus.req_ready, 1);
        for (int i = 0; i < N_ITEMS; i++) begin
            do_order(i, 1, 1, 0, ok, fp, ct, wt);
            check("abort_stock_zero", ct, 0);
        end

        // Till wrap: 0 - 6 = 250, then 250 + 12 = 6.
        do_cfg(2, 6, 5);
        do_order(2, 1, 0, 0, ok, fp, ct, wt);
        check("wrap_pre_total", total, 250);
        do_cfg(0, 3, 9);
        do_order(0, 4, 1, 0, ok, fp, ct, wt);
        check("wrap_total", total, 6);
        do_order(2, 0, 1, 0, ok, fp, ct, wt);
        check("qty0_fprice", fp, 0);

`ifdef FCIMS_LOWSTOCK_ALERT_EN
        do_cfg(3, 1, 3);
        do_order(3, 2, 1, 0, ok, fp, ct, wt);
        check("alert_set", low_stock, 1);
        do_order(3, 4, 0, 0, ok, fp, ct, wt);
        check("alert_clear", low_stock, 0);
`endif

        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 3) == 0)
                do_cfg($urandom_range(0, N_ITEMS - 1), $urandom_range(0, 15), $urandom_range(0, 15));
            else
                do_order($urandom_range(0, N_ITEMS - 1), $urandom_range(0, 15), $urandom_range(0, 1),
                         $urandom_range(0, 2), ok, fp, ct, wt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
